// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream_demux slice.
package stream_demux_pkg;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   localparam int ERR_CNT_W = 16;

   // Ceiling log2; returns 0 for values <= 1, callers clamp as needed.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// Single-entry holding slot for one demux output channel.
module stream_demux_slot
   import stream_demux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              drain,
   output logic              state,
   output logic [DATA_W-1:0] data
);

   slot_state_e st;

   assign state = st;

   // A load while FULL only happens when the old beat drains on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st   <= SLOT_EMPTY;
         data <= '0;
      end else begin
         case (st)
            SLOT_EMPTY: begin
               if (load) begin
                  st   <= SLOT_FULL;
                  data <= load_data;
               end
            end
            SLOT_FULL: begin
               if (load) begin
                  data <= load_data;
               end else if (drain) begin
                  st <= SLOT_EMPTY;
               end
            end
            default: st <= SLOT_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/stream_demux.sv
// One-to-N stream demux with a single-entry slot per channel.
// Optional feature macro: STREAM_DEMUX_ERR_EN (drop out-of-range beats and count them).
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int N_CH   = 8,
   localparam int SEL_W  = (clog2(N_CH) < 1) ? 1 : clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic [DATA_W-1:0]      in_data,
   output logic [N_CH-1:0]        out_valid,
   input  logic [N_CH-1:0]        out_ready,
   output logic [N_CH*DATA_W-1:0] out_data
`ifdef STREAM_DEMUX_ERR_EN
   ,
   output logic                   err_pulse,
   output logic [ERR_CNT_W-1:0]   err_cnt
`endif
);

   // Valid/ready: a beat moves on a rising edge where both are high; in_ready
   // never looks at in_valid, and a FULL slot stays put until its ready is high.
   logic            sel_hit;
   logic            sel_open;
   logic [N_CH-1:0] slot_state;

   always_comb begin
      sel_hit  = 1'b0;
      sel_open = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (in_sel == SEL_W'(k)) begin
            sel_hit  = 1'b1;
            sel_open = !out_valid[k] || out_ready[k];
         end
      end
   end

`ifdef STREAM_DEMUX_ERR_EN
   assign in_ready = !sel_hit || sel_open;
`else
   assign in_ready = sel_hit && sel_open;
`endif

   for (genvar k = 0; k < N_CH; k++) begin : g_slot
      stream_demux_slot #(
         .DATA_W(DATA_W)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (in_valid && in_ready && (in_sel == SEL_W'(k))),
         .load_data(in_data),
         .drain    (out_ready[k]),
         .state    (slot_state[k]),
         .data     (out_data[k*DATA_W +: DATA_W])
      );
      assign out_valid[k] = (slot_state[k] == SLOT_FULL);
   end

`ifdef STREAM_DEMUX_ERR_EN
   logic drop;

   assign drop = in_valid && !sel_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pulse <= 1'b0;
         err_cnt   <= '0;
      end else begin
         err_pulse <= drop;
         if (drop && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed + random bench for stream_demux with a per-beat scoreboard.
module tb_stream_demux;

  localparam int DW = 8;
  localparam int NC = 8;
  localparam int SW = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-channel instance
  logic             in_valid;
  logic             in_ready;
  logic [SW-1:0]    in_sel;
  logic [DW-1:0]    in_data;
  logic [NC-1:0]    out_valid;
  logic [NC-1:0]    out_ready;
  logic [NC*DW-1:0] out_data;

  // 5-channel instance for out-of-range selects
  logic             v5;
  logic             r5;
  logic [SW-1:0]    s5;
  logic [DW-1:0]    d5;
  logic [4:0]       ov5;
  logic [4:0]       or5;
  logic [5*DW-1:0]  od5;

`ifdef STREAM_DEMUX_ERR_EN
  logic        err_pulse8, err_pulse5;
  logic [15:0] err_cnt8, err_cnt5;
`endif

  stream_demux #(.DATA_W(DW), .N_CH(NC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef STREAM_DEMUX_ERR_EN
    , .err_pulse(err_pulse8), .err_cnt(err_cnt8)
`endif
  );

  stream_demux #(.DATA_W(DW), .N_CH(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v5), .in_ready(r5), .in_sel(s5), .in_data(d5),
    .out_valid(ov5), .out_ready(or5), .out_data(od5)
`ifdef STREAM_DEMUX_ERR_EN
    , .err_pulse(err_pulse5), .err_cnt(err_cnt5)
`endif
  );

  // scoreboard: {channel, data} per accepted beat
  int total = 0;
  int bad = 0;
  logic [SW+DW-1:0] exp_q[$];
  logic [NC-1:0]    model_full;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input int ch, input logic [DW-1:0] obs);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && exp_q[i][SW+DW-1:DW] == SW'(ch)) idx = i;
    if (idx < 0) begin
      total++;
      bad++;
      $error("FAIL sb_underflow ch=%0d observed=%0h expected=none", ch, obs);
    end else begin
      check($sformatf("ch%0d_data", ch), {56'd0, obs}, {56'd0, exp_q[idx][DW-1:0]});
      exp_q.delete(idx);
    end
  endtask

  task automatic drive(input logic v, input logic [SW-1:0] s, input logic [DW-1:0] d,
                       input logic [NC-1:0] rdy);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = rdy;
  endtask

  // one clock of the 8-channel instance, checked against the slot model
  task automatic step();
    logic acc;
    @(negedge clk);
    acc = in_valid && (!model_full[in_sel] || out_ready[in_sel]);
    check("in_ready", {63'd0, in_ready}, {63'd0, !model_full[in_sel] || out_ready[in_sel]});
    check("out_valid", {56'd0, out_valid}, {56'd0, model_full});
    for (int k = 0; k < NC; k++) begin
      if (model_full[k] && out_ready[k]) begin
        pop_check(k, out_data[k*DW +: DW]);
        model_full[k] = 1'b0;
      end
    end
    if (acc) begin
      exp_q.push_back({in_sel, in_data});
      model_full[in_sel] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    drive(1'b0, '0, '0, '0);
    v5 = 1'b0; s5 = '0; d5 = '0; or5 = '0;
    model_full = '0;

    // reset state
    #12;
    check("rst_out_valid", {56'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef STREAM_DEMUX_ERR_EN
    check("rst_err_cnt", {48'd0, err_cnt5}, 64'd0);
    check("rst_err_pulse", {63'd0, err_pulse5}, 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic routing, first edge after reset release
    drive(1'b1, 3'd3, 8'hA5, 8'h00);
    step();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    check("route_valid", {56'd0, out_valid}, 64'h08);
    check("route_data", {56'd0, out_data[31:24]}, 64'hA5);

    // back-pressure on slot 3 only
    drive(1'b1, 3'd3, 8'h3C, 8'h00);
    #1;
    check("bp_ready3", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 3'd4, 8'h5C, 8'h00);
    #1;
    check("bp_ready4", {63'd0, in_ready}, 64'd1);
    step();
    check("bp_valid", {56'd0, out_valid}, 64'h18);

    // drain and reload slot 3 on the same edge, twice
    drive(1'b1, 3'd3, 8'h11, 8'h08);
    step();
    check("dl_data_11", {56'd0, out_data[31:24]}, 64'h11);
    drive(1'b1, 3'd3, 8'h22, 8'h08);
    step();
    check("dl_data_22", {56'd0, out_data[31:24]}, 64'h22);
    check("dl_valid", {56'd0, out_valid}, 64'h18);
    drive(1'b0, 3'd0, 8'h00, 8'h08);
    step();

    // slot 4 held stable while other channels move
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, SW'(i % 3), 8'($urandom), 8'h07);
      step();
      check("hold_data4", {56'd0, out_data[39:32]}, 64'h5C);
    end

    // random traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), SW'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      step();
    end
    drive(1'b0, 3'd0, 8'h00, 8'hFF);
    step();
    step();
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    // asynchronous reset with slots 2 and 5 full
    drive(1'b1, 3'd2, 8'h77, 8'h00);
    step();
    drive(1'b1, 3'd5, 8'h99, 8'h00);
    step();
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    check("pre_rst_valid", {56'd0, out_valid}, 64'h24);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {56'd0, out_valid}, 64'd0);
    check("arst_data", out_data, 64'd0);
    check("arst_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    model_full = '0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 3'd6, 8'hC3, 8'h00);
    step();
    check("post_rst_valid", {56'd0, out_valid}, 64'h40);
    check("post_rst_data", {56'd0, out_data[55:48]}, 64'hC3);
    drive(1'b0, 3'd0, 8'h00, 8'hFF);
    step();

    // out-of-range select on the 5-channel instance
    v5 = 1'b1; s5 = 3'd1; d5 = 8'h42;
    @(posedge clk);
    #1;
    s5 = 3'd6; d5 = 8'hEE;
`ifdef STREAM_DEMUX_ERR_EN
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      v5 = (i < 3);
      @(negedge clk);
      if (i < 3) check("oor_ready", {63'd0, r5}, 64'd1);
      @(posedge clk);
      #1;
      pulses += int'(err_pulse5);
    end
    check("oor_pulses", 64'(pulses), 64'd3);
    check("oor_cnt", {48'd0, err_cnt5}, 64'd3);
    check("oor_valid", {59'd0, ov5}, 64'h02);
    v5 = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    v5 = 1'b0;
    check("sat_cnt", {48'd0, err_cnt5}, 64'hFFFF);
    check("cnt8_idle", {48'd0, err_cnt8}, 64'd0);
`else
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("oor_ready", {63'd0, r5}, 64'd0);
      check("oor_valid", {59'd0, ov5}, 64'h02);
      @(posedge clk);
      #1;
    end
    v5 = 1'b0;
`endif
    check("ch1_data5", {56'd0, od5[15:8]}, 64'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
